// File: rtl/snoopy_pkg.sv
// Shared definitions for the Snoopy runner game controller.
// Contents: game_state encodings and default parameter values used by the
// controller top and its bus interface.
package snoopy_pkg;

    // game_state encodings as seen on the bus.
    localparam logic [1:0] GS_ATTRACT = 2'b00;
    localparam logic [1:0] GS_PLAY    = 2'b01;
    localparam logic [1:0] GS_HIT     = 2'b10;
    localparam logic [1:0] GS_OVER    = 2'b11;

    localparam int unsigned TICK_DIV_DEFAULT       = 833333;
    localparam int unsigned DEBOUNCE_TICKS_DEFAULT = 3;
    localparam int unsigned LIVES_INIT_DEFAULT     = 3;
    localparam int unsigned HIT_FRAMES_DEFAULT     = 60;
    localparam int unsigned SCORE_W_DEFAULT        = 16;

endpackage

// File: rtl/snoopy_game_controller_if.sv
// Board/vertical-FSM side bus of the game controller.
// Inputs to controller : start_btn, jump_btn (raw async), collision, snoopy_on_ground.
// Outputs of controller: frame_tick, jump_pulse, physics_reset, game_state,
//                        score, lives, game_over.
// master = the controller, slave = the board / physics side.
interface snoopy_game_controller_if
    import snoopy_pkg::*;
#(
    parameter int unsigned SCORE_W = SCORE_W_DEFAULT
);
    logic               start_btn;
    logic               jump_btn;
    logic               collision;
    logic               snoopy_on_ground;
    logic               frame_tick;
    logic               jump_pulse;
    logic               physics_reset;
    logic [1:0]         game_state;
    logic [SCORE_W-1:0] score;
    logic [1:0]         lives;
    logic               game_over;

    modport master (
        input  start_btn, jump_btn, collision, snoopy_on_ground,
        output frame_tick, jump_pulse, physics_reset, game_state, score, lives, game_over
    );

    modport slave (
        output start_btn, jump_btn, collision, snoopy_on_ground,
        input  frame_tick, jump_pulse, physics_reset, game_state, score, lives, game_over
    );
endinterface

// File: rtl/snoopy_btn_conditioner.sv
// Button conditioner: 2-flop synchroniser followed by either a plain rising-edge
// detector (DEBOUNCE_TICKS == 0) or a tick-sampled debounce whose accepted level
// changes after DEBOUNCE_TICKS consecutive equal samples.
// Ports: clock, reset (sync, active-high), tick (sample strobe), btn (raw async),
//        rise (one-cycle pulse on accepted 0->1 transition).
module snoopy_btn_conditioner #(
    parameter int unsigned DEBOUNCE_TICKS = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic btn,
    output logic rise
);
    logic sync1_q, sync2_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    if (DEBOUNCE_TICKS == 0) begin : g_edge
        logic prev_q;
        logic unused_tick;

        assign unused_tick = tick;

        always_ff @(posedge clock) begin
            if (reset) prev_q <= 1'b0;
            else       prev_q <= sync2_q;
        end

        assign rise = sync2_q & ~prev_q;
    end else begin : g_debounce
        localparam int unsigned CntW = $clog2(DEBOUNCE_TICKS + 1);
        localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_TICKS);

        logic            sample_q;
        logic [CntW-1:0] cnt_q, cnt_d;
        logic            level_q, level_d;

        // cnt counts the run length of equal samples, saturating at CntMax.
        always_comb begin
            cnt_d   = cnt_q;
            level_d = level_q;
            if (tick) begin
                if (sync2_q != sample_q)  cnt_d = CntW'(1);
                else if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
                if (cnt_d == CntMax)      level_d = sync2_q;
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                sample_q <= 1'b0;
                cnt_q    <= '0;
                level_q  <= 1'b0;
            end else begin
                if (tick) sample_q <= sync2_q;
                cnt_q   <= cnt_d;
                level_q <= level_d;
            end
        end

        assign rise = level_d & ~level_q;
    end
endmodule

// File: rtl/snoopy_game_controller.sv
// Snoopy runner game sequencer: frame tick divider, button conditioning, jump gate,
// ATTRACT/PLAY/HIT/OVER state machine, score, lives and respawn counters.
// Ports: clock, reset (sync, active-high), bus (snoopy_game_controller_if.master).
module snoopy_game_controller
    import snoopy_pkg::*;
#(
    parameter int unsigned TICK_DIV       = TICK_DIV_DEFAULT,
    parameter int unsigned DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEFAULT,
    parameter int unsigned LIVES_INIT     = LIVES_INIT_DEFAULT,
    parameter int unsigned HIT_FRAMES     = HIT_FRAMES_DEFAULT,
    parameter int unsigned SCORE_W        = SCORE_W_DEFAULT
) (
    input logic                      clock,
    input logic                      reset,
    snoopy_game_controller_if.master bus
);
    localparam int unsigned TickW = $clog2(TICK_DIV);
    localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
    localparam int unsigned HitW = $clog2(HIT_FRAMES + 1);

    logic [TickW-1:0]   tick_cnt_q;
    logic               frame_tick_q;
    logic [1:0]         state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [1:0]         lives_q, lives_d;
    logic [HitW-1:0]    hit_q, hit_d;
    logic               pending_q, pending_d;
    logic               start_rise, jump_rise;

    // Free-running frame divider; frame_tick is registered so its period is TICK_DIV.
    always_ff @(posedge clock) begin
        if (reset) begin
            tick_cnt_q   <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            tick_cnt_q   <= (tick_cnt_q == TickLast) ? '0 : tick_cnt_q + TickW'(1);
            frame_tick_q <= (tick_cnt_q == TickLast);
        end
    end

    snoopy_btn_conditioner #(.DEBOUNCE_TICKS(0)) u_start_cond (
        .clock (clock),
        .reset (reset),
        .tick  (frame_tick_q),
        .btn   (bus.start_btn),
        .rise  (start_rise)
    );

    snoopy_btn_conditioner #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_jump_cond (
        .clock (clock),
        .reset (reset),
        .tick  (frame_tick_q),
        .btn   (bus.jump_btn),
        .rise  (jump_rise)
    );

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        lives_d = lives_q;
        hit_d   = hit_q;

        // A pending jump lives for exactly one frame: the next tick consumes it.
        pending_d = pending_q;
        if (jump_rise)         pending_d = 1'b1;
        else if (frame_tick_q) pending_d = 1'b0;

        case (state_q)
            GS_ATTRACT: begin
                if (start_rise) begin
                    state_d = GS_PLAY;
                    score_d = '0;
                    lives_d = 2'(LIVES_INIT);
                end
            end
            GS_PLAY: begin
                if (frame_tick_q) begin
                    if (bus.collision) begin
                        lives_d = lives_q - 2'd1;
                        if (lives_q == 2'd1) begin
                            state_d = GS_OVER;
                        end else begin
                            state_d = GS_HIT;
                            hit_d   = HitW'(HIT_FRAMES);
                        end
                    end else if (score_q != {SCORE_W{1'b1}}) begin
                        score_d = score_q + SCORE_W'(1);
                    end
                end
            end
            GS_HIT: begin
                if (frame_tick_q) begin
                    hit_d = hit_q - HitW'(1);
                    if (hit_q == HitW'(1)) state_d = GS_PLAY;
                end
            end
            GS_OVER: begin
                if (start_rise) state_d = GS_ATTRACT;
            end
            default: state_d = GS_ATTRACT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= GS_ATTRACT;
            score_q   <= '0;
            lives_q   <= 2'(LIVES_INIT);
            hit_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            lives_q   <= lives_d;
            hit_q     <= hit_d;
            pending_q <= pending_d;
        end
    end

    // Collision wins over jump on the same tick; reset suppresses a pulse immediately.
    assign bus.jump_pulse    = ~reset & frame_tick_q & pending_q & (state_q == GS_PLAY)
                             & bus.snoopy_on_ground & ~bus.collision;
    assign bus.frame_tick    = frame_tick_q;
    assign bus.physics_reset = reset | (state_q != GS_PLAY);
    assign bus.game_state    = state_q;
    assign bus.score         = score_q;
    assign bus.lives         = lives_q;
    assign bus.game_over     = (state_q == GS_OVER);
endmodule

// File: tb/tb_snoopy_game_controller.sv
// Directed bench for snoopy_game_controller with TICK_DIV=4, DEBOUNCE_TICKS=2,
// LIVES_INIT=2, HIT_FRAMES=3, SCORE_W=4. Inputs change and outputs are sampled
// on the falling clock edge.
module tb_snoopy_game_controller;
    import snoopy_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   pulses, off_tick, wide;

    snoopy_game_controller_if #(.SCORE_W(4)) bus ();

    snoopy_game_controller #(
        .TICK_DIV       (4),
        .DEBOUNCE_TICKS (2),
        .LIVES_INIT     (2),
        .HIT_FRAMES     (3),
        .SCORE_W        (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance to the next falling edge at which frame_tick is high.
    task automatic wait_tick();
        bit seen = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge clock);
            seen = bus.frame_tick;
        end
        if (!seen) check_val("tick_timeout", 0, 1);
    endtask

    // Hold jump for 'hold' cycles, observe 'total' cycles, raise on_ground at 'land_at'.
    task automatic run_jump(input int hold, input int total, input int land_at,
                            output int n_pulse, output int n_off, output int n_wide);
        bit prev = 1'b0;
        n_pulse = 0;
        n_off   = 0;
        n_wide  = 0;
        bus.jump_btn = 1'b1;
        for (int c = 0; c < total; c++) begin
            @(negedge clock);
            if (bus.jump_pulse) begin
                n_pulse++;
                if (!bus.frame_tick) n_off++;
                if (prev) n_wide++;
            end
            prev = bus.jump_pulse;
            if (c == hold) bus.jump_btn = 1'b0;
            if (c == land_at) bus.snoopy_on_ground = 1'b1;
        end
        bus.jump_btn = 1'b0;
    endtask

    task automatic press_start();
        bus.start_btn = 1'b1;
        repeat (3) @(negedge clock);
        bus.start_btn = 1'b0;
    endtask

    task automatic collide_on_tick();
        wait_tick();
        bus.collision = 1'b1;
        @(negedge clock);
        bus.collision = 1'b0;
    endtask

    initial begin
        bus.start_btn        = 1'b0;
        bus.jump_btn         = 1'b0;
        bus.collision        = 1'b0;
        bus.snoopy_on_ground = 1'b1;

        // 1: reset values and tick period
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_val("rst_jump_pulse", int'(bus.jump_pulse), 0);
        reset = 1'b0;
        check_val("rst_state", int'(bus.game_state), int'(GS_ATTRACT));
        check_val("rst_score", int'(bus.score), 0);
        check_val("rst_lives", int'(bus.lives), 2);
        check_val("rst_phys", int'(bus.physics_reset), 1);
        check_val("rst_over", int'(bus.game_over), 0);
        check_val("rst_tick", int'(bus.frame_tick), 0);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            check_val($sformatf("tick_phase%0d", i), int'(bus.frame_tick), (i % 4 == 0) ? 1 : 0);
        end

        // 2: start -> PLAY three clocks later, score counts ticks
        bus.start_btn = 1'b1;
        @(negedge clock);
        check_val("start_c1", int'(bus.game_state), int'(GS_ATTRACT));
        @(negedge clock);
        check_val("start_c2", int'(bus.game_state), int'(GS_ATTRACT));
        @(negedge clock);
        check_val("start_c3", int'(bus.game_state), int'(GS_PLAY));
        check_val("start_phys", int'(bus.physics_reset), 0);
        check_val("start_score", int'(bus.score), 0);
        bus.start_btn = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            wait_tick();
            @(negedge clock);
            check_val($sformatf("score_%0d", k), int'(bus.score), k);
        end

        // 3: jump on ground -> one pulse; airborne jump -> none, even after landing
        run_jump(12, 40, 1000, pulses, off_tick, wide);
        check_val("jump_count", pulses, 1);
        check_val("jump_on_tick", off_tick, 0);
        check_val("jump_width", wide, 0);
        bus.snoopy_on_ground = 1'b0;
        run_jump(12, 48, 24, pulses, off_tick, wide);
        check_val("air_jump_count", pulses, 0);
        check_val("play_score_sat", int'(bus.score), 15);

        // 4: collision with 2 lives -> HIT for 3 ticks, collision ignored in HIT
        collide_on_tick();
        check_val("hit_state", int'(bus.game_state), int'(GS_HIT));
        check_val("hit_lives", int'(bus.lives), 1);
        check_val("hit_phys", int'(bus.physics_reset), 1);
        collide_on_tick();
        check_val("hit_ign_state", int'(bus.game_state), int'(GS_HIT));
        check_val("hit_ign_lives", int'(bus.lives), 1);
        wait_tick();
        @(negedge clock);
        check_val("hit_t2_state", int'(bus.game_state), int'(GS_HIT));
        wait_tick();
        @(negedge clock);
        check_val("hit_t3_state", int'(bus.game_state), int'(GS_PLAY));
        check_val("hit_t3_score", int'(bus.score), 15);

        // 5: last life -> OVER; inputs ignored; start -> ATTRACT -> PLAY
        collide_on_tick();
        check_val("over_state", int'(bus.game_state), int'(GS_OVER));
        check_val("over_lives", int'(bus.lives), 0);
        check_val("over_flag", int'(bus.game_over), 1);
        bus.collision = 1'b1;
        run_jump(12, 24, 1000, pulses, off_tick, wide);
        bus.collision = 1'b0;
        check_val("over_jump", pulses, 0);
        check_val("over_hold_state", int'(bus.game_state), int'(GS_OVER));
        check_val("over_hold_lives", int'(bus.lives), 0);
        wait_tick();
        press_start();
        check_val("over_to_attract", int'(bus.game_state), int'(GS_ATTRACT));
        check_val("attract_score_kept", int'(bus.score), 15);
        check_val("attract_over_flag", int'(bus.game_over), 0);
        repeat (4) @(negedge clock);
        wait_tick();
        press_start();
        check_val("restart_state", int'(bus.game_state), int'(GS_PLAY));
        check_val("restart_score", int'(bus.score), 0);
        check_val("restart_lives", int'(bus.lives), 2);

        // Collision tick does not score; HIT freezes score
        wait_tick();
        @(negedge clock);
        check_val("re_score1", int'(bus.score), 1);
        collide_on_tick();
        check_val("re_hit_score", int'(bus.score), 1);
        check_val("re_hit_lives", int'(bus.lives), 1);
        for (int k = 1; k <= 3; k++) begin
            wait_tick();
            @(negedge clock);
            check_val($sformatf("re_hit_frozen%0d", k), int'(bus.score), 1);
        end
        check_val("re_play", int'(bus.game_state), int'(GS_PLAY));
        wait_tick();
        @(negedge clock);
        check_val("re_score2", int'(bus.score), 2);

        // Start edge in PLAY is dropped
        press_start();
        check_val("start_in_play", int'(bus.game_state), int'(GS_PLAY));

        // 6: saturation, then reset mid-PLAY
        for (int k = 0; k < 20; k++) wait_tick();
        @(negedge clock);
        check_val("sat_score", int'(bus.score), 15);
        bus.jump_btn = 1'b1;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_val("mid_rst_state", int'(bus.game_state), int'(GS_ATTRACT));
        check_val("mid_rst_score", int'(bus.score), 0);
        check_val("mid_rst_lives", int'(bus.lives), 2);
        check_val("mid_rst_tick", int'(bus.frame_tick), 0);
        check_val("mid_rst_pulse", int'(bus.jump_pulse), 0);
        check_val("mid_rst_phys", int'(bus.physics_reset), 1);
        reset = 1'b0;
        run_jump(4, 24, 1000, pulses, off_tick, wide);
        check_val("post_rst_pulse", pulses, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule
